// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NUM_REQ requesters.
// Optional macro ALU_ARB_ILLEGAL_OP_EN rejects opcodes 000/111 without driving the ALU.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [3*NUM_REQ-1:0]  req_opcode,
  input  logic [33*NUM_REQ-1:0] req_op1,
  input  logic [4*NUM_REQ-1:0]  req_op2,
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [31:0]           resp_result,
  output logic                  resp_overflow,
  output logic                  resp_error,
  output logic [IDX_W-1:0]      resp_owner,
  output logic [2:0]            alu_opcode,
  output logic [32:0]           alu_operand1,
  output logic [3:0]            alu_operand2,
  input  logic [31:0]           alu_res_out,
  input  logic                  alu_overflow
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic [2:0]       opc_a [NUM_REQ];
  logic [32:0]      op1_a [NUM_REQ];
  logic [3:0]       op2_a [NUM_REQ];
  logic [2:0]       sel_opcode;
  logic [32:0]      sel_op1;
  logic [3:0]       sel_op2;
  logic             is_illegal;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      opc_a[i] = req_opcode[3*i +: 3];
      op1_a[i] = req_op1[33*i +: 33];
      op2_a[i] = req_op2[4*i +: 4];
    end
  end

  // Scan from the farthest candidate back to the nearest so the nearest one
  // after last_grant is the final assignment and wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    // NOTE: every signal written here gets a default first, otherwise the
    // paths that skip an assignment would infer a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign sel_opcode = opc_a[grant_idx];
  assign sel_op1    = op1_a[grant_idx];
  assign sel_op2    = op2_a[grant_idx];

`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign is_illegal = (sel_opcode == 3'b000) || (sel_opcode == 3'b111);
`else
  assign is_illegal = 1'b0;
`endif

  // Gated by rst_n so no requester believes it was accepted while the core is held in reset.
  assign req_ready = (rst_n && state == IDLE && grant_valid) ? (NUM_REQ'(1) << grant_idx) : '0;

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= IDX_W'(NUM_REQ - 1);
      resp_owner    <= '0;
      resp_valid    <= '0;
      resp_result   <= '0;
      resp_overflow <= 1'b0;
      resp_error    <= 1'b0;
      // NOTE: the operand latches are reset too, because they drive output
      // ports that must read zero during reset.
      alu_opcode    <= 3'b000;
      alu_operand1  <= '0;
      alu_operand2  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            last_grant   <= grant_idx;
            resp_owner   <= grant_idx;
            alu_operand1 <= sel_op1;
            alu_operand2 <= sel_op2;
            resp_error   <= is_illegal;
            if (is_illegal) begin
              // Rejected opcodes never reach the ALU; answer straight away.
              alu_opcode    <= 3'b000;
              resp_result   <= '0;
              resp_overflow <= 1'b0;
              resp_valid    <= NUM_REQ'(1) << grant_idx;
              state         <= RESP;
            end else begin
              alu_opcode <= sel_opcode;
              state      <= EXEC;
            end
          end
        end
        EXEC: begin
          resp_result   <= alu_res_out;
          resp_overflow <= alu_overflow;
          resp_valid    <= NUM_REQ'(1) << resp_owner;
          state         <= RESP;
        end
        RESP: begin
          if (resp_ready[resp_owner]) begin
            resp_valid <= '0;
            alu_opcode <= 3'b000;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU datapath between NUM_REQ independent requesters.
- Arbitration is round-robin; each requester sees a valid/ready command handshake and a valid/ready response handshake.
- Accepts one operation at a time: it latches the operands, drives the ALU for one cycle, registers the result and overflow, then returns them to the owning requester.
- Sits between the ALU and its clients (decode/execute and debug ports).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of owner index; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester command valid
- req_ready  output  NUM_REQ  one-hot command accept
- req_opcode  input  3*NUM_REQ  packed opcodes; requester i at [3i+2:3i]
- req_op1  input  33*NUM_REQ  packed operand1
- req_op2  input  4*NUM_REQ  packed operand2
- resp_valid  output  NUM_REQ  one-hot response valid
- resp_ready  input  NUM_REQ  per-requester response accept
- resp_result  output  32  result for current owner
- resp_overflow  output  1  overflow for current owner
- resp_error  output  1  illegal-opcode flag (see Optional Feature)
- resp_owner  output  IDX_W  index of current owner
- alu_opcode  output  3  to ALU opcode
- alu_operand1  output  33  to ALU operand1
- alu_operand2  output  4  to ALU operand2
- alu_res_out  input  32  from ALU res_out
- alu_overflow  input  1  from ALU overflow

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs 0; alu_opcode = 3'b000 (ALU no-op).
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, grant the first requester searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - req_ready[grant] = 1 combinationally in this cycle only. The handshake completes on that edge.
  - Latch the winner's opcode/op1/op2 and owner index; set last_grant = grant; go to EXEC.
  - If no req_valid is set, req_ready = 0 and stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_opcode/alu_operand1/alu_operand2 driven from latches.
  - At the clock edge, register alu_res_out to resp_result and alu_overflow to resp_overflow; go to RESP.
  - Outside EXEC, ALU inputs are held at the latched values. Opcode is forced to 000 in IDLE.
- RESP:
  - resp_valid[owner] = 1; result, overflow, error and owner are held stable.
  - On resp_ready[owner] = 1: clear resp_valid and return to IDLE.
  - resp_ready bits of non-owners are ignored.
- Latency: accept at edge N; resp_valid seen in cycle N+2. Minimum issue interval is 3 cycles.
- Simultaneous requests: only one grant per IDLE cycle. Losers keep req_valid asserted and hold their operands stable until accepted.
- A requester with a response pending may raise a new req_valid; it is arbitrated only after returning to IDLE.
- req_valid dropped before acceptance: the request is simply not granted. No state change.
- Width rule: operands pass through unmodified. resp_result is ALU res_out[31:0]; the arbiter performs no arithmetic.
- Reset mid-operation (EXEC or RESP): the operation is discarded and no response is delivered.

Optional Feature:
- Macro ALU_ARB_ILLEGAL_OP_EN.
- Defined:
  - Opcodes 000 and 111 are rejected at acceptance. They skip EXEC (IDLE to RESP directly, latency 1 cycle).
  - Response is resp_result = 0, resp_overflow = 0, resp_error = 1.
  - The ALU is not driven with the illegal opcode.
- Undefined: every opcode goes through EXEC; resp_error is tied 0.

Test Plan:
1. Single request: req 0 issues ADD (001), op1 = 5, op2 = 3 → req_ready[0] = 1 for one cycle; resp_valid[0] two cycles later; resp_result = 8; resp_owner = 0.
2. Round-robin: all four req_valid held high, each with distinct SUB operands → grants in order 0, 1, 2, 3, 0. Each resp_result matches its own operands.
3. Response backpressure: resp_ready[2] held low 10 cycles while req 1 is valid → resp held stable throughout; no req_ready[1] until resp_ready[2] = 1.
4. Non-owner ready: resp_ready[1] = 1 while the owner is 0 → no state change; resp_valid[0] remains high.
5. Reset mid-EXEC: rst_n pulled low during EXEC → all outputs 0 immediately. After release, req 0 is granted first again.
6. With ALU_ARB_ILLEGAL_OP_EN: opcode 111 → resp_valid one cycle after accept, resp_error = 1, resp_result = 0, alu_opcode stays 000. Without the macro: goes through EXEC, resp_error = 0.
